// File: rtl/lock_controller_if.sv
// Canal-lock controller bus: request lights from the upstream light stages,
// acks back to them, and the gate/pump/level indications out of the lock.
interface lock_controller_if #(
  parameter int LEVEL_MAX = 15
);
  localparam int LVL_W = $clog2(LEVEL_MAX + 1);

  logic             arr_li;
  logic             dep_li;
  logic             arr_ack;
  logic             dep_ack;
  logic             low_gate_open;
  logic             high_gate_open;
  logic             filling;
  logic             draining;
  logic [LVL_W-1:0] level;
  logic             busy;

  modport master (
    output arr_li, dep_li,
    input  arr_ack, dep_ack, low_gate_open, high_gate_open,
           filling, draining, level, busy
  );

  modport slave (
    input  arr_li, dep_li,
    output arr_ack, dep_ack, low_gate_open, high_gate_open,
           filling, draining, level, busy
  );
endinterface

// File: rtl/lock_controller.sv
// Canal-lock sequencer: one boat transit at a time (prep level, open entry gate,
// move level, open exit gate). Moore FSM with every output registered.
module lock_controller #(
  parameter int LEVEL_MAX   = 15,
  parameter int GATE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  lock_controller_if.slave bus
);
  localparam int LVL_W = $clog2(LEVEL_MAX + 1);
  localparam int TMR_W = $clog2(GATE_CYCLES + 1);
  localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(LEVEL_MAX);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_OPEN_IN,
    S_MOVE,
    S_OPEN_OUT
  } state_t;

  state_t           r_state;
  logic             r_dir;
  logic [LVL_W-1:0] r_level;
  logic [TMR_W-1:0] r_timer;
  logic             r_arr_ack;
  logic             r_dep_ack;
  logic             r_low_gate;
  logic             r_high_gate;
  logic             r_filling;
  logic             r_draining;
  logic             r_busy;

  state_t           w_state_next;
  logic             w_dir_next;
  logic [LVL_W-1:0] w_level_next;
  logic [TMR_W-1:0] w_timer_next;
  logic             w_arr_ack_next;
  logic             w_dep_ack_next;
  logic [LVL_W-1:0] w_entry;
  logic [LVL_W-1:0] w_exit;
  logic [LVL_W-1:0] w_target;
  logic [LVL_W-1:0] w_step;

  assign w_entry = r_dir ? LVL_TOP : '0;
  assign w_exit  = r_dir ? '0 : LVL_TOP;

  always_comb begin
    w_state_next   = r_state;
    w_dir_next     = r_dir;
    w_level_next   = r_level;
    w_timer_next   = r_timer;
    w_arr_ack_next = 1'b0;
    w_dep_ack_next = 1'b0;
    // PREP heads for the entry level, MOVE for the exit level
    w_target = (r_state == S_PREP) ? w_entry : w_exit;
    w_step   = (r_level < w_target) ? r_level + LVL_W'(1) : r_level - LVL_W'(1);

    unique case (r_state)
      S_IDLE: begin
        if (bus.arr_li) begin
          w_dir_next     = 1'b0;
          w_arr_ack_next = 1'b1;
          if (r_level == '0) begin
            w_state_next = S_OPEN_IN;
            w_timer_next = TMR_LOAD;
          end else begin
            w_state_next = S_PREP;
          end
        end else if (bus.dep_li) begin
          w_dir_next     = 1'b1;
          w_dep_ack_next = 1'b1;
          if (r_level == LVL_TOP) begin
            w_state_next = S_OPEN_IN;
            w_timer_next = TMR_LOAD;
          end else begin
            w_state_next = S_PREP;
          end
        end
      end
      S_PREP: begin
        w_level_next = w_step;
        if (w_step == w_target) begin
          w_state_next = S_OPEN_IN;
          w_timer_next = TMR_LOAD;
        end
      end
      S_OPEN_IN: begin
        if (r_timer == '0) w_state_next = S_MOVE;
        else               w_timer_next = r_timer - TMR_W'(1);
      end
      S_MOVE: begin
        w_level_next = w_step;
        if (w_step == w_target) begin
          w_state_next = S_OPEN_OUT;
          w_timer_next = TMR_LOAD;
        end
      end
      S_OPEN_OUT: begin
        if (r_timer == '0) w_state_next = S_IDLE;
        else               w_timer_next = r_timer - TMR_W'(1);
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they line up with the state register.
  // In IDLE the level always sits at one end, so PREP direction follows dir alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_level     <= '0;
      r_timer     <= '0;
      r_arr_ack   <= 1'b0;
      r_dep_ack   <= 1'b0;
      r_low_gate  <= 1'b0;
      r_high_gate <= 1'b0;
      r_filling   <= 1'b0;
      r_draining  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dir       <= w_dir_next;
      r_level     <= w_level_next;
      r_timer     <= w_timer_next;
      r_arr_ack   <= w_arr_ack_next;
      r_dep_ack   <= w_dep_ack_next;
      r_low_gate  <= ((w_state_next == S_OPEN_IN)  && !w_dir_next) ||
                     ((w_state_next == S_OPEN_OUT) &&  w_dir_next);
      r_high_gate <= ((w_state_next == S_OPEN_IN)  &&  w_dir_next) ||
                     ((w_state_next == S_OPEN_OUT) && !w_dir_next);
      r_filling   <= ((w_state_next == S_PREP) &&  w_dir_next) ||
                     ((w_state_next == S_MOVE) && !w_dir_next);
      r_draining  <= ((w_state_next == S_PREP) && !w_dir_next) ||
                     ((w_state_next == S_MOVE) &&  w_dir_next);
      r_busy      <= (w_state_next != S_IDLE);
    end
  end

  assign bus.arr_ack        = r_arr_ack;
  assign bus.dep_ack        = r_dep_ack;
  assign bus.low_gate_open  = r_low_gate;
  assign bus.high_gate_open = r_high_gate;
  assign bus.filling        = r_filling;
  assign bus.draining       = r_draining;
  assign bus.level          = r_level;
  assign bus.busy           = r_busy;
endmodule
